// File: rtl/lsu_split_pkg.sv
// Shared definitions for the load/store splitter: memory access lengths,
// FSM encoding and the misalignment rule that selects the byte-split path.
package lsu_split_pkg;

   localparam logic [1:0] ML_BYTE = 2'b00;
   localparam logic [1:0] ML_HALF = 2'b01;
   localparam logic [1:0] ML_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_FINISH = 2'd2,
      ST_RESP   = 2'd3
   } lsu_state_t;

   // Length 2'b11 behaves as a word.
   function automatic logic is_misaligned(input logic [1:0] len, input logic [1:0] addr_lo);
      if (len == ML_BYTE) return 1'b0;
      if (len == ML_HALF) return addr_lo[0];
      return addr_lo != 2'b00;
   endfunction

   function automatic logic [1:0] split_last_beat(input logic [1:0] len);
      return (len == ML_HALF) ? 2'd1 : 2'd3;
   endfunction

endpackage

// File: rtl/lsu_split_load_extend.sv
// Load result extender: sign- or zero-extends a byte/halfword held in the
// low bits of a raw 32-bit value according to the RISC-V load funct3.
module load_extend
   import lsu_split_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [31:0] raw,
   output logic [31:0] result
);

   always_comb begin
      result = raw;
      case (funct3[1:0])
         ML_BYTE: result = {{24{raw[7] & ~funct3[2]}}, raw[7:0]};
         ML_HALF: result = {{16{raw[15] & ~funct3[2]}}, raw[15:0]};
         default: result = raw;
      endcase
   end

endmodule

// File: rtl/lsu_split.sv
// Load/store unit front end: passes aligned requests straight to memory and
// splits misaligned halfword/word requests into little-endian byte beats.
module lsu_split
   import lsu_split_pkg::*;
#(
   parameter int ADDRW = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [2:0]       req_funct3,
   input  logic [ADDRW-1:0] req_addr,
   input  logic [31:0]      req_wdata,
   output logic             resp_valid,
   output logic [31:0]      resp_rdata,
   output logic             resp_split,
   output logic             mem_we,
   output logic [2:0]       mem_funct3,
   output logic [ADDRW-1:0] mem_addr,
   output logic [31:0]      mem_wdata,
   input  logic [31:0]      mem_rdata
);

   lsu_state_t       state;
   logic [1:0]       beat;
   logic             we_q;
   logic             split_q;
   logic [2:0]       funct3_q;
   logic [ADDRW-1:0] addr_q;
   logic [31:0]      wdata_q;
   logic [31:0]      asm_q;

   logic             accept;
   logic [1:0]       last;
   logic [1:0]       cap_idx;
   logic [31:0]      asm_next;
   logic [31:0]      ext_out;

   assign req_ready  = (state == ST_IDLE) && !rst;
   assign accept     = req_valid && req_ready;
   assign last       = split_q ? split_last_beat(funct3_q[1:0]) : 2'd0;

   assign mem_we     = we_q && (state == ST_ACCESS) && !rst;
   assign mem_addr   = addr_q + ADDRW'(beat);
   assign mem_funct3 = split_q ? {1'b1, ML_BYTE} : funct3_q;
   assign mem_wdata  = split_q ? {24'b0, wdata_q[{beat, 3'b000} +: 8]} : wdata_q;

   // Read data lags its beat by one cycle; in FINISH the beat counter still
   // points at the final beat, whose byte is arriving now.
   assign cap_idx = (state == ST_FINISH) ? beat : beat - 2'd1;

   always_comb begin
      asm_next = asm_q;
      asm_next[{cap_idx, 3'b000} +: 8] = mem_rdata[7:0];
   end

   load_extend u_extend (
      .funct3 (funct3_q),
      .raw    (asm_next),
      .result (ext_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         beat       <= 2'd0;
         we_q       <= 1'b0;
         split_q    <= 1'b0;
         funct3_q   <= 3'b000;
         addr_q     <= '0;
         wdata_q    <= 32'h0;
         asm_q      <= 32'h0;
         resp_valid <= 1'b0;
         resp_rdata <= 32'h0;
         resp_split <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  we_q     <= req_we;
                  funct3_q <= req_funct3;
                  addr_q   <= req_addr;
                  wdata_q  <= req_wdata;
                  split_q  <= is_misaligned(req_funct3[1:0], req_addr[1:0]);
                  beat     <= 2'd0;
                  asm_q    <= 32'h0;
                  state    <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (split_q && (beat != 2'd0)) asm_q <= asm_next;
               if (beat == last) state <= ST_FINISH;
               else              beat  <= beat + 2'd1;
            end
            ST_FINISH: begin
               resp_valid <= 1'b1;
               resp_split <= split_q;
               if (we_q)         resp_rdata <= 32'h0;
               else if (split_q) resp_rdata <= ext_out;
               else              resp_rdata <= mem_rdata;
               state <= ST_RESP;
            end
            default: begin
               beat  <= 2'd0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
